key_check_engine: RTL and testbench

//  Responder side of the key-search handshake. Accepts one candidate key per transaction from
//  the search FSM/counter. Encrypts a known plaintext with it over ROUNDS iterative rounds.

---
 rtl/key_check_engine.sv | 130 +++++++++++++
 tb/tb_key_check_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_check_engine.sv
// key_check_engine: accepts one candidate key per transaction and encrypts a
// known plaintext with it over ROUNDS iterative rounds. It then compares the
// result with the target ciphertext and returns found/not-found with the key.
module key_check_engine #(
  parameter int W      = 16,
  parameter int ROUNDS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cand_valid_i,
  output logic         cand_ready_o,
  input  logic [W-1:0] cand_key_i,
  input  logic [W-1:0] plain_i,
  input  logic [W-1:0] target_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         res_found_o,
  output logic [W-1:0] res_key_o,
  output logic         busy_o
);

  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   k_q, k_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic           found_q, found_d;
  logic [W-1:0]   key_q, key_d;

  // One cipher round: key rotates left by one, state rotates left by three
  // and absorbs the rotated key (carry out of the top bit is dropped).
  logic [W-1:0]   k_rot;
  logic [W-1:0]   s_rot;
  logic [W-1:0]   s_new;
  logic           last_round;

  assign k_rot      = {k_q[W-2:0], k_q[W-1]};
  assign s_rot      = {s_q[W-4:0], s_q[W-1:W-3]};
  assign s_new      = s_rot + k_rot;
  assign last_round = (rnd_q == RW'(ROUNDS - 1));

  // State and datapath registers; reset drops any candidate in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      tgt_q   <= '0;
      rnd_q   <= '0;
      found_q <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      rnd_q   <= rnd_d;
      found_q <= found_d;
      key_q   <= key_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    k_d          = k_q;
    tgt_d        = tgt_q;
    rnd_d        = rnd_q;
    found_d      = found_q;
    key_d        = key_q;
    cand_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    busy_o       = 1'b0;

    case (state_q)
      IDLE: begin
        cand_ready_o = 1'b1;
        if (cand_valid_i) begin
          // Snapshot all inputs so later changes cannot disturb this result.
          s_d     = plain_i ^ cand_key_i;
          k_d     = cand_key_i;
          tgt_d   = target_i;
          key_d   = cand_key_i;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy_o = 1'b1;
        k_d    = k_rot;
        s_d    = s_new;
        rnd_d  = rnd_q + RW'(1);
        if (last_round) begin
          found_d = (s_new == tgt_q);
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the reset condition.
        state_d = IDLE;
        s_d     = '0;
        k_d     = '0;
        tgt_d   = '0;
        rnd_d   = '0;
        found_d = 1'b0;
        key_d   = '0;
      end
    endcase
  end

  assign res_found_o = found_q;
  assign res_key_o   = key_q;

endmodule

// File: tb/tb_key_check_engine.sv
// Bench for key_check_engine: a ROUNDS=1 instance for the arithmetic corner
// vectors and a ROUNDS=8 instance for latency, hold, reset and streaming.
`timescale 1ns/1ps
module tb_key_check_engine;

  typedef struct {
    logic [15:0] key;
    logic        found;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q1[$];
  exp_t q8[$];
  exp_t e1, e8;

  // ROUNDS=1 instance signals
  logic        v1, cr1, rv1, rr1, rf1, bz1, ef1, prv1;
  logic [15:0] key1, pl1, tg1, rk1;
  int          acc_cnt1;

  // ROUNDS=8 instance signals
  logic        v8, cr8, rv8, rr8, rf8, bz8, ef8, prv8;
  logic [15:0] key8, pl8, tg8, rk8;
  int          acc_cnt8, acc_last8;

  key_check_engine #(.W(16), .ROUNDS(1)) u1 (
    .clk(clk), .reset(reset),
    .cand_valid_i(v1), .cand_ready_o(cr1), .cand_key_i(key1),
    .plain_i(pl1), .target_i(tg1),
    .res_valid_o(rv1), .res_ready_i(rr1), .res_found_o(rf1),
    .res_key_o(rk1), .busy_o(bz1)
  );

  key_check_engine #(.W(16), .ROUNDS(8)) u8 (
    .clk(clk), .reset(reset),
    .cand_valid_i(v8), .cand_ready_o(cr8), .cand_key_i(key8),
    .plain_i(pl8), .target_i(tg8),
    .res_valid_o(rv8), .res_ready_i(rr8), .res_found_o(rf8),
    .res_key_o(rk8), .busy_o(bz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_res(string tag, exp_t e, logic [15:0] k, logic f, int lat);
    $display("%s result key=%h found=%b latency=%0d", tag, k, f, cyc - e.acc);
    check({tag, "_res_key"}, {16'h0, k}, {16'h0, e.key});
    check({tag, "_res_found"}, {31'h0, f}, {31'h0, e.found});
    check({tag, "_latency"}, cyc - e.acc, lat);
  endtask

  // Scoreboard push: expected result recorded at each accepted candidate.
  always @(posedge clk) begin
    if (!reset && v1 && cr1) begin
      q1.push_back('{key: key1, found: ef1, acc: cyc + 1});
      acc_cnt1 <= acc_cnt1 + 1;
    end
    if (!reset && v8 && cr8) begin
      q8.push_back('{key: key8, found: ef8, acc: cyc + 1});
      acc_cnt8  <= acc_cnt8 + 1;
      acc_last8 <= cyc + 1;
    end
  end

  // Monitor: pops and compares whenever a new result is presented.
  always @(negedge clk) begin
    if (rv1 && !prv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_result actual key=%h required none", rk1);
      end else begin
        e1 = q1.pop_front();
        check_res("u1", e1, rk1, rf1, 1);
      end
    end
    if (rv8 && !prv8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8_unexpected_result actual key=%h required none", rk8);
      end else begin
        e8 = q8.pop_front();
        check_res("u8", e8, rk8, rf8, 8);
      end
    end
    prv1 <= rv1;
    prv8 <= rv8;
  end

  task automatic wait_accept1();
    int start;
    start = acc_cnt1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt1 != start) return;
    end
    checks++; errors++;
    $display("FAIL u1_accept_timeout actual none required accept");
  endtask

  task automatic wait_accept8();
    int start;
    start = acc_cnt8;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt8 != start) return;
    end
    checks++; errors++;
    $display("FAIL u8_accept_timeout actual none required accept");
  endtask

  task automatic offer1(logic [15:0] k, logic [15:0] p, logic [15:0] t, logic f);
    v1 = 1'b1; key1 = k; pl1 = p; tg1 = t; ef1 = f;
    wait_accept1();
    v1 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q8.size() == 0) break;
    end
    #1;
    check("scoreboard_drained", q1.size() + q8.size(), 0);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    acc_cnt1 = 0; acc_cnt8 = 0; acc_last8 = 0;
    prv1 = 1'b0; prv8 = 1'b0;
    reset = 1'b1;
    v1 = 0; key1 = 0; pl1 = 0; tg1 = 0; rr1 = 0; ef1 = 0;
    v8 = 0; key8 = 0; pl8 = 0; tg8 = 0; rr8 = 0; ef8 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cand_ready", {31'h0, cr8}, 1);
    check("rst_res_valid", {31'h0, rv8}, 0);
    check("rst_res_found", {31'h0, rf8}, 0);
    check("rst_res_key", {16'h0, rk8}, 0);
    check("rst_busy", {31'h0, bz8}, 0);
    check("rst_u1_cand_ready", {31'h0, cr1}, 1);

    // ROUNDS=1 vectors: basic, rotate wrap (hit and miss), add overflow
    @(posedge clk); #1;
    rr1 = 1'b1;
    offer1(16'h0001, 16'h0000, 16'h000A, 1'b1);
    offer1(16'h8000, 16'h0000, 16'h0005, 1'b1);
    offer1(16'h8000, 16'h0000, 16'h0004, 1'b0);
    offer1(16'hFFFF, 16'h0000, 16'hFFFE, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("u1_idle_keeps_res_key", {16'h0, rk1}, 32'hFFFF);
    check("u1_idle_keeps_res_found", {31'h0, rf1}, 1);
    check("u1_idle_res_valid", {31'h0, rv1}, 0);

    // ROUNDS=8 with res_ready low: exact latency, hold, no accept in DONE
    @(posedge clk); #1;
    v8 = 1'b1; key8 = 16'h0002; pl8 = 16'h0000; tg8 = 16'hACAA; ef8 = 1'b1;
    wait_accept8();
    key8 = 16'h0003; ef8 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("hold_res_valid_k%0d", k), {31'h0, rv8}, (k >= 8) ? 1 : 0);
      check($sformatf("hold_cand_ready_k%0d", k), {31'h0, cr8}, 0);
    end
    check("hold_busy", {31'h0, bz8}, 1);
    check("hold_res_key", {16'h0, rk8}, 32'h0002);
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
    check("release_res_valid", {31'h0, rv8}, 0);
    check("release_cand_ready", {31'h0, cr8}, 1);
    check("release_busy", {31'h0, bz8}, 0);
    wait_accept8();
    v8 = 1'b0;
    rr8 = 1'b1;
    wait_drain();

    // Reset three edges into ROUND drops the candidate
    @(posedge clk); #1;
    v8 = 1'b1; key8 = 16'h0005; pl8 = 16'h0000; tg8 = 16'h0000; ef8 = 1'b0;
    wait_accept8();
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", {31'h0, bz8}, 0);
    check("midrst_res_valid", {31'h0, rv8}, 0);
    check("midrst_cand_ready", {31'h0, cr8}, 1);
    check("midrst_res_key", {16'h0, rk8}, 0);
    q8.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("midrst_no_result_k%0d", k), {31'h0, rv8}, 0);
    end

    // Back-to-back stream of keys 0..3, inputs disturbed mid-ROUND
    @(posedge clk); #1;
    rr8 = 1'b1; pl8 = 16'h0000; tg8 = 16'hACAA; v8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int prev;
      prev = acc_last8;
      key8 = 16'(k);
      ef8  = (k == 2);
      wait_accept8();
      if (k > 0) check($sformatf("stream_spacing_k%0d", k), acc_last8 - prev, 10);
      key8 = 16'($urandom);
      pl8  = 16'($urandom);
      tg8  = 16'($urandom);
      repeat (4) @(posedge clk);
      #1;
      pl8 = 16'h0000;
      tg8 = 16'hACAA;
    end
    v8 = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
